// File: rtl/pll_reconfig_ctrl.sv
// Reconfiguration and lock supervisor for a PLLVR with dynamic divider selects: holds the PLL in reset
// while selects change, then qualifies lock (timeout, bounded retry, settle window); all outputs registered.
module pll_reconfig_ctrl #(
    parameter int unsigned      DIV_W         = 6,
    parameter logic [DIV_W-1:0] IDSEL_INIT    = '0,
    parameter logic [DIV_W-1:0] FBDSEL_INIT   = '0,
    parameter logic [DIV_W-1:0] ODSEL_INIT    = '0,
    parameter int unsigned      RST_CYCLES    = 16,
    parameter int unsigned      LOCK_TIMEOUT  = 4096,
    parameter int unsigned      SETTLE_CYCLES = 64,
    parameter int unsigned      MAX_RETRY     = 3
) (
    input  logic                               clkin_i,
    input  logic                               reset_i,
    input  logic                               cfg_valid_i,
    output logic                               cfg_ready_o,
    input  logic [DIV_W-1:0]                   cfg_idsel_i,
    input  logic [DIV_W-1:0]                   cfg_fbdsel_i,
    input  logic [DIV_W-1:0]                   cfg_odsel_i,
    output logic [DIV_W-1:0]                   pll_idsel_o,
    output logic [DIV_W-1:0]                   pll_fbdsel_o,
    output logic [DIV_W-1:0]                   pll_odsel_o,
    output logic                               pll_reset_o,
    input  logic                               pll_lock_i,
    output logic                               locked_o,
    output logic                               busy_o,
    output logic                               err_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt_o
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);
    localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned ST_W    = $clog2(SETTLE_CYCLES + 1);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0]    ST_DONE   = ST_W'(SETTLE_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_APPLY,
        ST_RESET_HOLD,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t             state_q;
    logic               pll_reset_q;
    logic               locked_q;
    logic               busy_q;
    logic               err_q;
    logic               cfg_ready_q;
    logic [RETRY_W-1:0] retry_q;
    logic [DIV_W-1:0]   idsel_q, fbdsel_q, odsel_q;
    logic [DIV_W-1:0]   shd_idsel_q, shd_fbdsel_q, shd_odsel_q;
    logic               sync_q, lock_s_q;
    logic [RST_W-1:0]   rst_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [ST_W-1:0]    settle_cnt_q;

    logic               hs;
    logic               timeout;
    logic               settle_done;
    logic [RETRY_W-1:0] retry_d;
    logic [TO_W-1:0]    to_cnt_d;
    logic [ST_W-1:0]    settle_cnt_d;
    logic [RST_W-1:0]   rst_cnt_d;

    always_comb begin
        hs           = cfg_valid_i && cfg_ready_q;
        timeout      = (to_cnt_q == TO_LAST);
        settle_done  = (state_q == ST_SETTLE) && lock_s_q && (settle_cnt_q == ST_DONE);
        retry_d      = retry_q + RETRY_W'(1);
        to_cnt_d     = to_cnt_q + TO_W'(1);
        settle_cnt_d = (state_q == ST_WAIT_LOCK) ? ST_W'(1) : settle_cnt_q + ST_W'(1);
        rst_cnt_d    = rst_cnt_q + RST_W'(1);
    end

    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            state_q      <= ST_RESET_HOLD;
            pll_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            cfg_ready_q  <= 1'b0;
            retry_q      <= '0;
            idsel_q      <= IDSEL_INIT;
            fbdsel_q     <= FBDSEL_INIT;
            odsel_q      <= ODSEL_INIT;
            shd_idsel_q  <= IDSEL_INIT;
            shd_fbdsel_q <= FBDSEL_INIT;
            shd_odsel_q  <= ODSEL_INIT;
            sync_q       <= 1'b0;
            lock_s_q     <= 1'b0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            settle_cnt_q <= '0;
        end else begin
            sync_q   <= pll_lock_i;
            lock_s_q <= sync_q;

            // cfg_ready is only ever set in RUN/FAIL, so a handshake overrides those states' own transitions
            if (hs) begin
                state_q      <= ST_APPLY;
                pll_reset_q  <= 1'b1;
                locked_q     <= 1'b0;
                busy_q       <= 1'b1;
                err_q        <= 1'b0;
                cfg_ready_q  <= 1'b0;
                retry_q      <= '0;
                shd_idsel_q  <= cfg_idsel_i;
                shd_fbdsel_q <= cfg_fbdsel_i;
                shd_odsel_q  <= cfg_odsel_i;
            end else begin
                case (state_q)
                    ST_APPLY: begin
                        state_q   <= ST_RESET_HOLD;
                        rst_cnt_q <= '0;
                        idsel_q   <= shd_idsel_q;
                        fbdsel_q  <= shd_fbdsel_q;
                        odsel_q   <= shd_odsel_q;
                    end
                    ST_RESET_HOLD: begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_q     <= ST_WAIT_LOCK;
                            pll_reset_q <= 1'b0;
                            to_cnt_q    <= '0;
                        end else begin
                            rst_cnt_q <= rst_cnt_d;
                        end
                    end
                    ST_WAIT_LOCK, ST_SETTLE: begin
                        to_cnt_q <= to_cnt_d;
                        if (settle_done) begin
                            state_q     <= ST_RUN;
                            locked_q    <= 1'b1;
                            busy_q      <= 1'b0;
                            cfg_ready_q <= 1'b1;
                            retry_q     <= '0;
                        end else if (timeout) begin
                            retry_q     <= retry_d;
                            pll_reset_q <= 1'b1;
                            if (retry_d == RETRY_MAX) begin
                                state_q     <= ST_FAIL;
                                err_q       <= 1'b1;
                                busy_q      <= 1'b0;
                                cfg_ready_q <= 1'b1;
                            end else begin
                                state_q   <= ST_RESET_HOLD;
                                rst_cnt_q <= '0;
                            end
                        end else if (lock_s_q) begin
                            state_q      <= ST_SETTLE;
                            settle_cnt_q <= settle_cnt_d;
                        end else begin
                            state_q <= ST_WAIT_LOCK;
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s_q) begin
                            state_q     <= ST_RESET_HOLD;
                            pll_reset_q <= 1'b1;
                            locked_q    <= 1'b0;
                            busy_q      <= 1'b1;
                            cfg_ready_q <= 1'b0;
                            retry_q     <= '0;
                            rst_cnt_q   <= '0;
                        end
                    end
                    ST_FAIL: begin
                        state_q <= ST_FAIL;
                    end
                    default: begin
                        state_q     <= ST_RESET_HOLD;
                        pll_reset_q <= 1'b1;
                        rst_cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready_o  = cfg_ready_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_odsel_o  = odsel_q;
    assign pll_reset_o  = pll_reset_q;
    assign locked_o     = locked_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign retry_cnt_o  = retry_q;

endmodule
